// File: rtl/unpack_pkg.sv
// Shared constants for the word-to-byte unpacker: data widths and one-hot FSM state encoding.
package unpack_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    READ_WORD = 5'b00010,
    WRITE_LO  = 5'b00100,
    WRITE_HI  = 5'b01000,
    DONE      = 5'b10000
  } state_t;
endpackage

// File: rtl/ram_dp_async_read.sv
// Dual-port RAM: synchronous write port, asynchronous read port, contents not reset.
module ram_dp_async_read #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/word_to_byte_unpack_fsm.sv
// Reads IN_DEPTH 16-bit words and writes them as byte pairs into a 2*IN_DEPTH x 8 RAM,
// three cycles per word; start is ignored while busy and done holds until the next start.
module word_to_byte_unpack_fsm
  import unpack_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ram_in_we,
  input  logic [$clog2(IN_DEPTH)-1:0] ram_in_addr_wr,
  input  logic [WORD_W-1:0]           ram_in_data_wr,
  input  logic [$clog2(IN_DEPTH):0]   ram_out_addr_rd,
  output logic [BYTE_W-1:0]           ram_out_data_rd,
  input  logic                        start_in,
  output logic                        busy_out,
  output logic                        done_out
);
  localparam int AW = $clog2(IN_DEPTH);

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_word_ptr, w_ptr_nxt;
  logic [WORD_W-1:0] r_word_buf, w_buf_nxt;
  logic              r_done, w_done_nxt;

  logic [AW-1:0]     w_in_raddr;
  logic [WORD_W-1:0] w_in_rdat;
  logic              w_out_we;
  logic [AW:0]       w_out_addr;
  logic [BYTE_W-1:0] w_out_dat;
  logic [BYTE_W-1:0] w_lo_byte, w_hi_byte;

  // Even address gets the low byte when LSB_FIRST, otherwise the high byte.
  assign w_lo_byte = LSB_FIRST ? r_word_buf[BYTE_W-1:0] : r_word_buf[WORD_W-1:BYTE_W];
  assign w_hi_byte = LSB_FIRST ? r_word_buf[WORD_W-1:BYTE_W] : r_word_buf[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_word_ptr <= '0;
      r_word_buf <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_ptr <= w_ptr_nxt;
      r_word_buf <= w_buf_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_word_ptr;
    w_buf_nxt   = r_word_buf;
    w_done_nxt  = r_done;
    w_in_raddr  = '0;
    w_out_we    = 1'b0;
    w_out_addr  = '0;
    w_out_dat   = '0;
    unique case (r_state)
      IDLE: begin
        if (start_in) begin
          w_state_nxt = READ_WORD;
          w_ptr_nxt   = '0;
          w_done_nxt  = 1'b0;
        end
      end
      READ_WORD: begin
        // Async read: a same-edge host write to this address lands after capture.
        w_in_raddr  = r_word_ptr;
        w_buf_nxt   = w_in_rdat;
        w_state_nxt = WRITE_LO;
      end
      WRITE_LO: begin
        w_out_we    = 1'b1;
        w_out_addr  = {r_word_ptr, 1'b0};
        w_out_dat   = w_lo_byte;
        w_state_nxt = WRITE_HI;
      end
      WRITE_HI: begin
        w_out_we   = 1'b1;
        w_out_addr = {r_word_ptr, 1'b1};
        w_out_dat  = w_hi_byte;
        if (r_word_ptr == AW'(IN_DEPTH - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_ptr_nxt   = r_word_ptr + AW'(1);
          w_state_nxt = READ_WORD;
        end
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy_out = (r_state != IDLE);
  assign done_out = r_done;

  ram_dp_async_read #(.WIDTH(WORD_W), .DEPTH(IN_DEPTH)) u_ram_in (
    .clk     (clk),
    .i_we    (ram_in_we),
    .i_waddr (ram_in_addr_wr),
    .i_wdata (ram_in_data_wr),
    .i_raddr (w_in_raddr),
    .o_rdata (w_in_rdat)
  );

  ram_dp_async_read #(.WIDTH(BYTE_W), .DEPTH(2 * IN_DEPTH)) u_ram_out (
    .clk     (clk),
    .i_we    (w_out_we),
    .i_waddr (w_out_addr),
    .i_wdata (w_out_dat),
    .i_raddr (ram_out_addr_rd),
    .o_rdata (ram_out_data_rd)
  );
endmodule

// File: tb/tb_word_to_byte_unpack_fsm.sv
// Directed and random checks of the word-to-byte unpacker against a byte-order reference model.
module tb_word_to_byte_unpack_fsm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, start;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [4:0]  raddr;
  logic [7:0]  rdata;
  logic        busy, done;

  logic        we2, start2;
  logic [3:0]  waddr2;
  logic [15:0] wdata2;
  logic [4:0]  raddr2;
  logic [7:0]  rdata2;
  logic        busy2, done2;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model [16];
  logic [15:0] model2 [16];

  always #5 clk = ~clk;

  word_to_byte_unpack_fsm #(.IN_DEPTH(16), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ram_in_we(we), .ram_in_addr_wr(waddr),
    .ram_in_data_wr(wdata), .ram_out_addr_rd(raddr), .ram_out_data_rd(rdata),
    .start_in(start), .busy_out(busy), .done_out(done));

  word_to_byte_unpack_fsm #(.IN_DEPTH(16), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .ram_in_we(we2), .ram_in_addr_wr(waddr2),
    .ram_in_data_wr(wdata2), .ram_out_addr_rd(raddr2), .ram_out_data_rd(rdata2),
    .start_in(start2), .busy_out(busy2), .done_out(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte at output address idx, derived from the word it came from and the byte order.
  function automatic logic [7:0] exp_byte(input logic [15:0] w, input int idx, input bit lsb);
    bit take_high;
    take_high = ((idx % 2) == 1) == lsb;
    return take_high ? 8'((w >> 8) & 16'h00FF) : 8'(w & 16'h00FF);
  endfunction

  task automatic load(input int a, input logic [15:0] d);
    we = 1'b1; waddr = 4'(a); wdata = d;
    tick();
    we = 1'b0;
    model[a] = d;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    raddr = 5'(a);
    #1;
    d = rdata;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 32; i++) begin
      rd(i, d);
      chk($sformatf("%s_byte%0d", tag, i), 32'(d), 32'(exp_byte(model[i / 2], i, 1'b1)));
    end
  endtask

  // Pulse start, then count busy cycles and the edge (relative to the start edge) where done rises.
  task automatic run(input int repulse_at, output int busy_c, output int done_e);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; busy_c = 0; done_e = -1;
    while (n < 200 && done_e < 0) begin
      if (busy) busy_c++;
      if (done) done_e = n;
      if (done_e < 0) begin
        start = (n == repulse_at);
        tick();
        n++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int bc, de, n, cnt, dcnt;
    int de1, de2;
    logic [7:0] d;
    rst_n = 1'b0; start = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    start2 = 1'b0; we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

    // Reset held with start high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // Ramp pattern
    for (int k = 0; k < 16; k++) load(k, 16'((8'h10 + k) * 256 + k));
    run(-1, bc, de);
    chk("ramp_busy_cycles", 32'(bc), 32'd49);
    chk("ramp_done_edge", 32'(de), 32'd49);
    rd(0, d);  chk("ramp_out0", 32'(d), 32'h00);
    rd(1, d);  chk("ramp_out1", 32'(d), 32'h10);
    rd(30, d); chk("ramp_out30", 32'(d), 32'h0F);
    rd(31, d); chk("ramp_out31", 32'(d), 32'h1F);
    check_all("ramp");

    // Start pulsed mid-run must be ignored
    for (int k = 0; k < 16; k++) load(k, 16'($urandom));
    run(10, bc, de);
    chk("repulse_done_edge", 32'(de), 32'd49);
    chk("repulse_busy_cycles", 32'(bc), 32'd49);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) cnt++;
    end
    chk("repulse_no_second_run", 32'(cnt), 32'd0);
    chk("done_holds", 32'(done), 32'd1);
    check_all("repulse");

    // Random words
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) load(k, 16'($urandom));
      run(-1, bc, de);
      chk("rand_done_edge", 32'(de), 32'd49);
      check_all($sformatf("rand%0d", r));
    end

    // Reset in the middle of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    load(0, 16'h1234);
    run(-1, bc, de);
    chk("rerun_done_edge", 32'(de), 32'd49);
    rd(0, d); chk("rerun_out0", 32'(d), 32'h34);
    rd(1, d); chk("rerun_out1", 32'(d), 32'h12);
    check_all("rerun");

    // Start held high: back-to-back runs
    start = 1'b1;
    tick();
    cnt = 0; dcnt = 0; de1 = -1; de2 = -1;
    for (n = 0; n < 120; n++) begin
      if (!busy) cnt++;
      if (done) begin
        dcnt++;
        if (de1 < 0) de1 = n; else if (de2 < 0) de2 = n;
      end
      tick();
    end
    start = 1'b0;
    chk("held_done_edge1", 32'(de1), 32'd49);
    chk("held_done_edge2", 32'(de2), 32'd99);
    chk("held_done_cycles", 32'(dcnt), 32'd2);
    chk("held_busy_low_cycles", 32'(cnt), 32'd2);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("held_drain_idle", 32'(busy), 32'd0);

    // MSB-first instance
    for (int k = 0; k < 16; k++) begin
      model2[k] = (k == 0) ? 16'hBEEF : 16'($urandom);
      we2 = 1'b1; waddr2 = 4'(k); wdata2 = model2[k];
      tick();
    end
    we2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
    end
    chk("msb_done_edge", 32'(n), 32'd49);
    raddr2 = 5'd0; #1; chk("msb_out0", 32'(rdata2), 32'hBE);
    raddr2 = 5'd1; #1; chk("msb_out1", 32'(rdata2), 32'hEF);
    for (int i = 0; i < 32; i++) begin
      raddr2 = 5'(i);
      #1;
      chk($sformatf("msb_byte%0d", i), 32'(rdata2), 32'(exp_byte(model2[i / 2], i, 1'b0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/word_to_byte_unpack_fsm.md
Name: word_to_byte_unpack_fsm

Overview:
- Moves a block of 16-bit words into byte-wide storage: reads each word from a 16x16 input RAM, splits it into two bytes, and writes them to consecutive addresses of a 32x8 output RAM.
- Host loads the input RAM, pulses start, waits for done, then reads bytes back.
- Both RAMs are dual-port: synchronous write, asynchronous read.

Parameters:
- IN_DEPTH, 16, number of 16-bit words in the input RAM. Output RAM depth is 2*IN_DEPTH.
- LSB_FIRST, 1, if 1 the low byte goes to the even address; if 0 the high byte goes to the even address.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ram_in_we  input  1  host write enable, input RAM
- ram_in_addr_wr  input  $clog2(IN_DEPTH)  host write address, input RAM
- ram_in_data_wr  input  16  host write data, input RAM
- ram_out_addr_rd  input  $clog2(IN_DEPTH)+1  host read address, output RAM
- ram_out_data_rd  output  8  async read data, output RAM
- start_in  input  1  request to run one transfer
- busy_out  output  1  transfer in progress
- done_out  output  1  registered; set when a transfer completes

Behaviour:
- Reset: state=IDLE, word_ptr=0, word_buf=0, done_out=0, busy_out=0. RAM contents are not cleared.
- State machine (one-hot): IDLE, READ_WORD, WRITE_LO, WRITE_HI, DONE.
- IDLE: if start_in=1 at the edge, go to READ_WORD, clear word_ptr to 0 and clear done_out. Otherwise stay in IDLE.
- READ_WORD: input RAM read address = word_ptr; word_buf latches the read data at the edge; next state WRITE_LO.
- WRITE_LO: output RAM we=1, addr={word_ptr,1'b0}. Data = word_buf[7:0] if LSB_FIRST=1, else word_buf[15:8]. Next state WRITE_HI.
- WRITE_HI: output RAM we=1, addr={word_ptr,1'b1}, data = the other byte.
  - If word_ptr==IN_DEPTH-1, go to DONE.
  - Otherwise word_ptr++ and go to READ_WORD.
- DONE: done_out<=1; next state IDLE.
- Output RAM write enable, address and data are combinational from state, word_ptr and word_buf. In all other states, write enable=0 and read address=0.
- busy_out = (state != IDLE), decoded from the registered state.
- Latency:
  - 3 cycles per word.
  - With start accepted at edge 0, done_out rises at edge 3*IN_DEPTH+1 (edge 49 at default).
  - busy_out is high for 49 cycles.
- done_out stays high until the next accepted start or reset.
- start_in while busy is ignored. It is not queued.
- start_in held high: a new transfer is accepted on the IDLE cycle after DONE, so done_out is high for exactly 1 cycle. Back-to-back runs have a period of 3*IN_DEPTH+2 cycles.
- Host write to the input RAM during a transfer is allowed. On a same-address, same-cycle collision with READ_WORD, word_buf captures the pre-write value.
- Host read of the output RAM during a transfer returns partially updated data. There is no interlock.
- Reset mid-operation returns to the reset values immediately. The output RAM keeps whatever was already written.
- word_ptr width is $clog2(IN_DEPTH). It must not wrap; termination is by the IN_DEPTH-1 compare.

Decomposition:
- Package unpack_pkg holds:
  - state localparams IDLE, READ_WORD, WRITE_LO, WRITE_HI, DONE (5-bit one-hot)
  - BYTE_W=8, WORD_W=16
- Sub-module: the team's existing dual-port async-read RAM primitive ram_dp_async_read, instantiated twice:
  - input RAM: WIDTH=16, DEPTH=IN_DEPTH
  - output RAM: WIDTH=8, DEPTH=2*IN_DEPTH
- FSM, counter and byte mux live in the top module.

Test Plan:
1. Assert rst_n=0 with start_in=1 → busy_out=0 and done_out=0 throughout. After release with start_in=0, both stay 0.
2. Load word k = {8'h10+k, 8'hk} for k=0..15, then pulse start for 1 cycle. Required response:
   - busy_out high for 49 cycles.
   - done_out rises 49 edges after the start edge.
   - RAM_OUT[0]=8'h00, RAM_OUT[1]=8'h10, RAM_OUT[30]=8'h0F, RAM_OUT[31]=8'h1F.
3. LSB_FIRST=0, word0=16'hBEEF, start → RAM_OUT[0]=8'hBE, RAM_OUT[1]=8'hEF.
4. Start pulsed again at cycle 10 of a run → ignored. Single done at edge 49, no second run.
5. Assert rst_n=0 at cycle 20, then restart after reloading word0=16'h1234. Required response:
   - During reset: busy_out=0 and done_out=0 immediately.
   - After the rerun: done at edge 49, RAM_OUT[0]=8'h34, RAM_OUT[1]=8'h12.
6. Hold start_in=1 for 120 cycles → done_out 1-cycle pulses at edges 49 and 99; busy_out low for exactly 1 cycle between runs.
